// File: rtl/regfile_banked.sv
// Banked general-purpose register file: one write port, two combinational
// read ports, a synchronous active-bank switch, optional write-through
// bypass, and a handshaked engine that streams out every register of a bank.
module regfile_banked #(
  parameter  int WIDTH  = 16,
  parameter  int NREGS  = 8,
  parameter  int NBANKS = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS),
  localparam int BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             LD_REG,
  input  logic [AW-1:0]    DR,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  input  logic [WIDTH-1:0] In,
  output logic [WIDTH-1:0] SR1_Out,
  output logic [WIDTH-1:0] SR2_Out,
  input  logic             Bank_Sw,
  input  logic [BW-1:0]    Bank_Sel,
  output logic [BW-1:0]    Active_Bank,
  input  logic             Dump_Start,
  input  logic [BW-1:0]    Dump_Bank,
  output logic             Dump_Valid,
  input  logic             Dump_Ready,
  output logic [WIDTH-1:0] Dump_Data,
  output logic [AW-1:0]    Dump_Idx,
  output logic             Dump_Busy,
  output logic             Dump_Done
);

  localparam bit            BYP      = (BYPASS != 0);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_t;

  logic [WIDTH-1:0] regs [NBANKS][NREGS];
  logic [BW-1:0]    active_bank;

  dump_state_t      dump_state;
  logic [BW-1:0]    dump_bank_p1;
  logic [AW-1:0]    dump_idx_p1;
  logic [WIDTH-1:0] dump_data_p1;
  logic             dump_vld_p1;
  logic             dump_busy_p1;
  logic             dump_done_p1;

  // Storage: a write always lands in the bank that is active during this cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < NBANKS; b++) begin
        for (int r = 0; r < NREGS; r++) begin
          regs[b][r] <= '0;
        end
      end
    end else if (LD_REG) begin
      regs[active_bank][DR] <= In;
    end
  end

  // Active bank register; takes effect on reads from the next cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active_bank <= '0;
    end else if (Bank_Sw) begin
      active_bank <= Bank_Sel;
    end
  end

  // Combinational read ports with optional forwarding of the write in flight
  always_comb begin
    SR1_Out = regs[active_bank][SR1];
    SR2_Out = regs[active_bank][SR2];
    if (BYP && LD_REG && (DR == SR1)) begin
      SR1_Out = In;
    end
    if (BYP && LD_REG && (DR == SR2)) begin
      SR2_Out = In;
    end
  end

  // Dump engine: captures one word per accepted handshake from its latched
  // bank; every output is registered so Dump_Ready never reaches them
  // combinationally, and a captured word ignores later writes to its source.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dump_state   <= IDLE;
      dump_bank_p1 <= '0;
      dump_idx_p1  <= '0;
      dump_data_p1 <= '0;
      dump_vld_p1  <= 1'b0;
      dump_busy_p1 <= 1'b0;
      dump_done_p1 <= 1'b0;
    end else begin
      case (dump_state)
        IDLE: begin
          dump_done_p1 <= 1'b0;
          if (Dump_Start) begin
            dump_bank_p1 <= Dump_Bank;
            dump_idx_p1  <= '0;
            dump_data_p1 <= regs[Dump_Bank][0];
            dump_vld_p1  <= 1'b1;
            dump_busy_p1 <= 1'b1;
            dump_state   <= SEND;
          end
        end
        SEND: begin
          if (dump_vld_p1 && Dump_Ready) begin
            if (dump_idx_p1 == LAST_IDX) begin
              dump_vld_p1  <= 1'b0;
              dump_done_p1 <= 1'b1;
              dump_state   <= DONE;
            end else begin
              dump_idx_p1  <= dump_idx_p1 + 1'b1;
              dump_data_p1 <= regs[dump_bank_p1][dump_idx_p1 + 1'b1];
            end
          end
        end
        DONE: begin
          dump_done_p1 <= 1'b0;
          dump_busy_p1 <= 1'b0;
          dump_state   <= IDLE;
        end
        default: begin
          dump_vld_p1  <= 1'b0;
          dump_busy_p1 <= 1'b0;
          dump_done_p1 <= 1'b0;
          dump_state   <= IDLE;
        end
      endcase
    end
  end

  assign Active_Bank = active_bank;
  assign Dump_Valid  = dump_vld_p1;
  assign Dump_Data   = dump_data_p1;
  assign Dump_Idx    = dump_idx_p1;
  assign Dump_Busy   = dump_busy_p1;
  assign Dump_Done   = dump_done_p1;

endmodule

// File: tb/tb_regfile_banked.sv
// Directed bench for regfile_banked: a bypassing and a non-bypassing instance
// share all inputs; a vector table covers reads/writes/bank switching, and
// hand-written sequences cover the dump engine and mid-dump reset.
module tb_regfile_banked;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        LD_REG;
  logic [2:0]  DR, SR1, SR2;
  logic [15:0] In;
  logic        Bank_Sw;
  logic        Bank_Sel;
  logic        Dump_Start;
  logic        Dump_Bank;
  logic        Dump_Ready;

  logic [15:0] SR1_Out, SR2_Out;
  logic        Active_Bank;
  logic        Dump_Valid, Dump_Busy, Dump_Done;
  logic [15:0] Dump_Data;
  logic [2:0]  Dump_Idx;

  logic [15:0] nb_SR1_Out, nb_SR2_Out;
  logic        nb_Active_Bank;
  logic        nb_Dump_Valid, nb_Dump_Busy, nb_Dump_Done;
  logic [15:0] nb_Dump_Data;
  logic [2:0]  nb_Dump_Idx;

  int checks = 0;
  int errors = 0;

  regfile_banked #(.WIDTH(16), .NREGS(8), .NBANKS(2), .BYPASS(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .LD_REG(LD_REG), .DR(DR), .SR1(SR1), .SR2(SR2),
    .In(In), .SR1_Out(SR1_Out), .SR2_Out(SR2_Out), .Bank_Sw(Bank_Sw),
    .Bank_Sel(Bank_Sel), .Active_Bank(Active_Bank), .Dump_Start(Dump_Start),
    .Dump_Bank(Dump_Bank), .Dump_Valid(Dump_Valid), .Dump_Ready(Dump_Ready),
    .Dump_Data(Dump_Data), .Dump_Idx(Dump_Idx), .Dump_Busy(Dump_Busy),
    .Dump_Done(Dump_Done)
  );

  regfile_banked #(.WIDTH(16), .NREGS(8), .NBANKS(2), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Reset_n(Reset_n), .LD_REG(LD_REG), .DR(DR), .SR1(SR1), .SR2(SR2),
    .In(In), .SR1_Out(nb_SR1_Out), .SR2_Out(nb_SR2_Out), .Bank_Sw(Bank_Sw),
    .Bank_Sel(Bank_Sel), .Active_Bank(nb_Active_Bank), .Dump_Start(Dump_Start),
    .Dump_Bank(Dump_Bank), .Dump_Valid(nb_Dump_Valid), .Dump_Ready(Dump_Ready),
    .Dump_Data(nb_Dump_Data), .Dump_Idx(nb_Dump_Idx), .Dump_Busy(nb_Dump_Busy),
    .Dump_Done(nb_Dump_Done)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        ld;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] din;
    logic        sw;
    logic        sel;
    logic [15:0] e1;   // bypass instance SR1_Out
    logic [15:0] e2;   // bypass instance SR2_Out
    logic [15:0] n1;   // non-bypass instance SR1_Out
    logic [15:0] n2;   // non-bypass instance SR2_Out
    logic        eab;  // Active_Bank during the cycle
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    LD_REG = 1'b0; DR = '0; SR1 = '0; SR2 = '0; In = '0;
    Bank_Sw = 1'b0; Bank_Sel = 1'b0;
    Dump_Start = 1'b0; Dump_Bank = 1'b0; Dump_Ready = 1'b0;
  endtask

  task automatic chk_bank_zero(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i); SR2 = 3'(7 - i);
      #1;
      if (SR1_Out !== 16'h0 || SR2_Out !== 16'h0 ||
          nb_SR1_Out !== 16'h0 || nb_SR2_Out !== 16'h0) bad++;
    end
    chk(name, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // vector table: {ld, dr, sr1, sr2, din, sw, sel, e1, e2, n1, n2, eab}
    vt[0] = '{1'b0, 3'd0, 3'd0, 3'd7, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vt[1] = '{1'b1, 3'd3, 3'd3, 3'd3, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000, 1'b0};
    vt[2] = '{1'b0, 3'd0, 3'd3, 3'd0, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000, 1'b0};
    vt[3] = '{1'b1, 3'd6, 3'd3, 3'd5, 16'h3000, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000, 1'b0};
    vt[4] = '{1'b1, 3'd6, 3'd6, 3'd6, 16'h1111, 1'b1, 1'b1, 16'h1111, 16'h1111, 16'h3000, 16'h3000, 1'b0};
    vt[5] = '{1'b0, 3'd0, 3'd6, 3'd3, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vt[6] = '{1'b1, 3'd2, 3'd2, 3'd6, 16'hA5A5, 1'b0, 1'b0, 16'hA5A5, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vt[7] = '{1'b0, 3'd0, 3'd2, 3'd6, 16'h0000, 1'b1, 1'b0, 16'hA5A5, 16'h0000, 16'hA5A5, 16'h0000, 1'b1};
    vt[8] = '{1'b0, 3'd0, 3'd6, 3'd2, 16'h0000, 1'b0, 1'b0, 16'h1111, 16'h0000, 16'h1111, 16'h0000, 1'b0};
    vt[9] = '{1'b0, 3'd0, 3'd3, 3'd6, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h1111, 16'hBEEF, 16'h1111, 1'b0};

    // reset
    idle_inputs();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_active_bank", Active_Bank, 0);
    chk("rst_dump_busy",   Dump_Busy,   0);
    chk("rst_dump_valid",  Dump_Valid,  0);
    chk("rst_dump_done",   Dump_Done,   0);
    chk("rst_dump_data",   Dump_Data,   0);
    chk("rst_dump_idx",    Dump_Idx,    0);
    chk_bank_zero("rst_bank0_zero");
    Bank_Sw = 1'b1; Bank_Sel = 1'b1;
    tick();
    Bank_Sw = 1'b0; Bank_Sel = 1'b0;
    chk("rst_switch_to_b1", Active_Bank, 1);
    chk_bank_zero("rst_bank1_zero");
    Bank_Sw = 1'b1; Bank_Sel = 1'b0;
    tick();
    Bank_Sw = 1'b0;
    chk("rst_switch_to_b0", Active_Bank, 0);

    // table-driven read/write/bank vectors
    for (int v = 0; v < 10; v++) begin
      LD_REG = vt[v].ld; DR = vt[v].dr; SR1 = vt[v].sr1; SR2 = vt[v].sr2;
      In = vt[v].din; Bank_Sw = vt[v].sw; Bank_Sel = vt[v].sel;
      #1;
      chk($sformatf("vec%0d_sr1", v),    SR1_Out,     vt[v].e1);
      chk($sformatf("vec%0d_sr2", v),    SR2_Out,     vt[v].e2);
      chk($sformatf("vec%0d_nb_sr1", v), nb_SR1_Out,  vt[v].n1);
      chk($sformatf("vec%0d_nb_sr2", v), nb_SR2_Out,  vt[v].n2);
      chk($sformatf("vec%0d_bank", v),   Active_Bank, vt[v].eab);
      tick();
    end
    idle_inputs();

    // load Rn = 0x0100 + n in bank 0
    for (int n = 0; n < 8; n++) begin
      LD_REG = 1'b1; DR = 3'(n); In = 16'h0100 + 16'(n);
      tick();
    end
    LD_REG = 1'b0;

    // dump bank 0 with Ready high; a mid-dump start and a start in DONE are ignored
    Dump_Bank = 1'b0; Dump_Start = 1'b1; Dump_Ready = 1'b1;
    tick();
    Dump_Start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("d1_valid%0d", k), Dump_Valid, 1);
      chk($sformatf("d1_idx%0d", k),   Dump_Idx,   k);
      chk($sformatf("d1_data%0d", k),  Dump_Data,  32'h0100 + k);
      chk($sformatf("d1_busy%0d", k),  Dump_Busy,  1);
      if (k == 3) begin
        Dump_Start = 1'b1; Dump_Bank = 1'b1;
      end else begin
        Dump_Start = 1'b0; Dump_Bank = 1'b0;
      end
      tick();
    end
    chk("d1_done_pulse",  Dump_Done,  1);
    chk("d1_done_valid",  Dump_Valid, 0);
    chk("d1_done_busy",   Dump_Busy,  1);
    Dump_Start = 1'b1;
    tick();
    Dump_Start = 1'b0;
    chk("d1_idle_done",   Dump_Done,  0);
    chk("d1_idle_busy",   Dump_Busy,  0);
    chk("d1_idle_valid",  Dump_Valid, 0);

    // dump with Ready 1010..., R2 overwritten while word 2 is stalled
    Dump_Bank = 1'b0; Dump_Start = 1'b1; Dump_Ready = 1'b1;
    tick();
    Dump_Start = 1'b0;
    for (int c = 0; c < 15; c++) begin
      int w;
      w = (c + 1) / 2;
      Dump_Ready = (c % 2 == 0);
      chk($sformatf("d2_valid_c%0d", c), Dump_Valid, 1);
      chk($sformatf("d2_idx_c%0d", c),   Dump_Idx,   w);
      chk($sformatf("d2_data_c%0d", c),  Dump_Data,  32'h0100 + w);
      if (c == 3) begin
        LD_REG = 1'b1; DR = 3'd2; In = 16'hFFFF;
      end else begin
        LD_REG = 1'b0;
      end
      tick();
    end
    LD_REG = 1'b0; Dump_Ready = 1'b0;
    chk("d2_done_pulse", Dump_Done,  1);
    chk("d2_done_valid", Dump_Valid, 0);
    tick();
    chk("d2_idle_busy",  Dump_Busy,  0);
    SR1 = 3'd2; SR2 = 3'd1;
    #1;
    chk("d2_r2_updated", SR1_Out, 16'hFFFF);
    chk("d2_r1_intact",  SR2_Out, 16'h0101);

    // reset dropped while word 4 is presented
    Dump_Bank = 1'b0; Dump_Start = 1'b1; Dump_Ready = 1'b1;
    tick();
    Dump_Start = 1'b0;
    repeat (4) tick();
    chk("d3_word4_idx",   Dump_Idx,   4);
    chk("d3_word4_valid", Dump_Valid, 1);
    Reset_n = 1'b0;
    #1;
    chk("d3_rst_valid", Dump_Valid, 0);
    chk("d3_rst_busy",  Dump_Busy,  0);
    chk("d3_rst_done",  Dump_Done,  0);
    chk("d3_rst_data",  Dump_Data,  0);
    chk("d3_rst_idx",   Dump_Idx,   0);
    @(negedge Clk);
    Reset_n = 1'b1;
    idle_inputs();
    tick();
    chk("d3_after_done", Dump_Done,   0);
    chk("d3_after_busy", Dump_Busy,   0);
    chk("d3_after_bank", Active_Bank, 0);
    chk_bank_zero("d3_bank0_zero");
    Bank_Sw = 1'b1; Bank_Sel = 1'b1;
    tick();
    Bank_Sw = 1'b0;
    chk_bank_zero("d3_bank1_zero");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
